// File: rtl/coin_feeder_fsm_pkg.sv
// Shared state encoding and width helpers for the coin feeder controller.
// Imported by the interface, the top level and the timer.
package coin_feeder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INSERT    = 3'd1;
  localparam state_t ST_GAP       = 3'd2;
  localparam state_t ST_WAIT_COLA = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  // Width of the requested-quantity bus and of the remaining-colas counter.
  localparam int NUM_W = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_feeder_fsm_if.sv
// Buyer/vendor signal bundle: master is the coin feeder, slave is the vendor or bench side.
// pi_pause exists only when COIN_FEEDER_PAUSE_EN is defined.
interface coin_feeder_fsm_if #(
  parameter int CNT_W = 8
);
  import coin_feeder_pkg::*;

  logic             pi_buy;
  logic [NUM_W-1:0] pi_num;
  logic             pi_cola;
`ifdef COIN_FEEDER_PAUSE_EN
  logic             pi_pause;
`endif
  logic             po_money;
  logic             po_busy;
  logic             po_done;
  logic             po_err;
  logic [CNT_W-1:0] po_bought;

`ifdef COIN_FEEDER_PAUSE_EN
  modport master (
    input  pi_buy, pi_num, pi_cola, pi_pause,
    output po_money, po_busy, po_done, po_err, po_bought
  );
  modport slave (
    output pi_buy, pi_num, pi_cola, pi_pause,
    input  po_money, po_busy, po_done, po_err, po_bought
  );
`else
  modport master (
    input  pi_buy, pi_num, pi_cola,
    output po_money, po_busy, po_done, po_err, po_bought
  );
  modport slave (
    output pi_buy, pi_num, pi_cola,
    input  po_money, po_busy, po_done, po_err, po_bought
  );
`endif

endinterface

// File: rtl/coin_feeder_fsm_cycle_timer.sv
// Loadable down-counter with a zero flag; load wins over enable and the count stops at zero.
// Zero flag is registered state, so it lags a load by one cycle.
module cycle_timer
  import coin_feeder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/coin_feeder_fsm.sv
// Auto-buyer: pulses PRICE coins per cola with GAP idle cycles between, waits up to TIMEOUT cycles for the cola.
// Outputs decode registered state only; COIN_FEEDER_PAUSE_EN adds pi_pause, which freezes everything and masks coins.
module coin_feeder_fsm
  import coin_feeder_pkg::*;
#(
  parameter int PRICE   = 3,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  coin_feeder_fsm_if.master bus
);

  localparam int COIN_W = cnt_width(PRICE);
  localparam int TMR_W  = cnt_width((GAP > TIMEOUT) ? GAP : TIMEOUT);

  localparam logic [COIN_W-1:0] LAST_COIN = COIN_W'(PRICE - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TMR_W-1:0]  TO_LOAD   = TMR_W'(TIMEOUT - 1);
  // With no gap the next coin follows immediately.
  localparam state_t            ST_NEXT_COIN = (GAP == 0) ? ST_INSERT : ST_GAP;

  state_t             r_state;
  logic [COIN_W-1:0]  r_coin_cnt;
  logic [NUM_W-1:0]   r_remaining;
  logic               r_err;
  logic [CNT_W-1:0]   r_bought;

  state_t             w_state_nxt;
  logic [COIN_W-1:0]  w_coin_nxt;
  logic [NUM_W-1:0]   w_rem_nxt;
  logic               w_err_nxt;
  logic [CNT_W-1:0]   w_bought_nxt;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_en;
  logic               w_tmr_zero;
  logic               w_take_cola;
  logic               w_pause;

`ifdef COIN_FEEDER_PAUSE_EN
  assign w_pause = bus.pi_pause;
`else
  assign w_pause = 1'b0;
`endif

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_load     (w_tmr_load & ~w_pause),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en & ~w_pause),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_coin_nxt   = r_coin_cnt;
    w_rem_nxt    = r_remaining;
    w_err_nxt    = r_err;
    w_bought_nxt = r_bought;
    w_tmr_load   = 1'b0;
    w_tmr_val    = GAP_LOAD;
    w_tmr_en     = 1'b0;
    w_take_cola  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.pi_buy) begin
          w_err_nxt = 1'b0;
          if (bus.pi_num != '0) begin
            w_rem_nxt   = bus.pi_num;
            w_coin_nxt  = '0;
            w_state_nxt = ST_INSERT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_INSERT: begin
        w_coin_nxt = r_coin_cnt + COIN_W'(1);
        if (r_coin_cnt == LAST_COIN) begin
          // A vendor that answers in the same cycle as the final coin is honoured here.
          if (bus.pi_cola) begin
            w_take_cola = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_COLA;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TO_LOAD;
          end
        end else begin
          w_state_nxt = ST_NEXT_COIN;
          w_tmr_load  = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_INSERT;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_WAIT_COLA: begin
        if (bus.pi_cola) begin
          w_take_cola = 1'b1;
        end else if (w_tmr_zero) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_take_cola) begin
      w_bought_nxt = (r_bought == '1) ? r_bought : r_bought + CNT_W'(1);
      w_rem_nxt    = r_remaining - NUM_W'(1);
      w_coin_nxt   = '0;
      if (r_remaining == NUM_W'(1)) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_NEXT_COIN;
        w_tmr_load  = 1'b1;
        w_tmr_val   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_coin_cnt  <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_bought    <= '0;
    end else if (!w_pause) begin
      r_state     <= w_state_nxt;
      r_coin_cnt  <= w_coin_nxt;
      r_remaining <= w_rem_nxt;
      r_err       <= w_err_nxt;
      r_bought    <= w_bought_nxt;
    end
  end

  // A paused INSERT keeps its state, so the coin is re-issued once pause drops.
  assign bus.po_money  = (r_state == ST_INSERT) & ~w_pause;
  assign bus.po_busy   = (r_state != ST_IDLE);
  assign bus.po_done   = (r_state == ST_DONE);
  assign bus.po_err    = r_err;
  assign bus.po_bought = r_bought;

endmodule

// File: tb/tb_coin_feeder_fsm.sv
// Bench for coin_feeder_fsm: directed vector table, reset/GAP=0/saturation sequences, then random buys vs a timeline model.
module tb_coin_feeder_fsm;

  localparam int PRICE   = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int BUDGET  = 300;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  coin_feeder_fsm_if #(.CNT_W(CNT_W)) bus ();
  coin_feeder_fsm #(.PRICE(PRICE), .GAP(GAP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  coin_feeder_fsm_if #(.CNT_W(2)) bus0 ();
  coin_feeder_fsm #(.PRICE(3), .GAP(0), .TIMEOUT(8), .CNT_W(2)) dut_g0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus0)
  );

  typedef struct {
    int          num;
    int          delay;
    int          exp_done;
    logic [63:0] exp_mask;
    int          exp_got;
    int          exp_err;
  } vec_t;

  vec_t        vecs [9];
  int          checks = 0;
  int          errors = 0;
  int          model_total = 0;
  int          dl [16];
  logic        obs_money [0:BUDGET+1];
  logic        exp_money [0:BUDGET+1];
  int          obs_done, obs_err, obs_bought, busy_gaps;
  int          m_done, m_err, m_got, mism, rnum, rsel;
  int          g_done;
  logic [63:0] mask, g_mask;
  logic [1:0]  g_bought;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Issue one buy on the main DUT; the vendor answers dl[j] cycles after the last coin of cola j (<0: never).
  task automatic exec_buy(input int num);
    int coins = 0;
    int due   = -1;
    int c     = 0;
    int idx;
    for (int i = 0; i <= BUDGET + 1; i++) obs_money[i] = 1'b0;
    obs_done = 0; obs_err = 0; obs_bought = 0; busy_gaps = 0;
    bus.pi_buy = 1'b1; bus.pi_num = 4'(num); bus.pi_cola = 1'b0;
    while (obs_done == 0 && c < BUDGET) begin
      @(posedge sys_clk); #1; c++;
      obs_money[c] = bus.po_money;
      if (bus.po_busy !== 1'b1) busy_gaps++;
      bus.pi_buy = 1'($urandom_range(0, 1));
      bus.pi_num = 4'($urandom_range(0, 15));
      if (bus.po_money === 1'b1) begin
        coins++;
        idx = coins / PRICE - 1;
        if (coins % PRICE == 0 && idx < 16 && dl[idx] >= 0) due = c + dl[idx];
      end
      bus.pi_cola = (c == due);
      if (bus.po_done === 1'b1) begin
        obs_done = c; obs_err = int'(bus.po_err); obs_bought = int'(bus.po_bought);
        bus.pi_buy = 1'b0; bus.pi_cola = 1'b0;
      end
    end
    if (obs_done == 0) begin
      checks++; errors++;
      $display("FAIL done_wait: no po_done within %0d cycles", BUDGET);
    end
    bus.pi_buy = 1'b0; bus.pi_cola = 1'b0;
    @(posedge sys_clk); #1;
    check("idle_after_done", {bus.po_busy, bus.po_done}, 2'b00);
  endtask

  // Timeline model: coins every GAP+1 cycles, cola accepted dl cycles after the last coin, timeout after TIMEOUT.
  task automatic model_buy(input int num, output int done, output int err, output int got);
    int t = 1;
    int last;
    for (int i = 0; i <= BUDGET + 1; i++) exp_money[i] = 1'b0;
    done = 1; err = 0; got = 0;
    for (int j = 0; j < num; j++) begin
      for (int i = 0; i < PRICE; i++) exp_money[t + i * (GAP + 1)] = 1'b1;
      last = t + (PRICE - 1) * (GAP + 1);
      if (dl[j] < 0) begin
        err = 1; done = last + TIMEOUT + 1;
        break;
      end
      got++;
      done = last + dl[j] + 1;
      t    = last + dl[j] + 1 + GAP;
    end
  endtask

  // GAP=0 DUT with a vendor that answers in the same cycle as every third coin.
  task automatic exec_g0(input int num, output int done, output logic [63:0] m, output logic [1:0] bought);
    int coins = 0;
    int c     = 0;
    done = 0; m = '0; bought = '0;
    bus0.pi_buy = 1'b1; bus0.pi_num = 4'(num);
    while (done == 0 && c < 63) begin
      @(posedge sys_clk); #1; c++;
      bus0.pi_buy = 1'b0;
      if (bus0.po_money === 1'b1) begin m[c] = 1'b1; coins++; end
      bus0.pi_cola = (bus0.po_money === 1'b1) && (coins % 3 == 0);
      if (bus0.po_done === 1'b1) begin done = c; bought = bus0.po_bought; bus0.pi_cola = 1'b0; end
    end
    bus0.pi_cola = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1,  1,  9, 64'h92,    1, 0};
    vecs[1] = '{2,  1, 19, 64'h24892, 2, 0};
    vecs[2] = '{1, -1, 16, 64'h92,    0, 1};
    vecs[3] = '{1,  1,  9, 64'h92,    1, 0};
    vecs[4] = '{0,  1,  1, 64'h0,     0, 0};
    vecs[5] = '{1,  0,  8, 64'h92,    1, 0};
    vecs[6] = '{1,  8, 16, 64'h92,    1, 0};
    vecs[7] = '{1, -1, 16, 64'h92,    0, 1};
    vecs[8] = '{0,  1,  1, 64'h0,     0, 0};

    bus.pi_buy = 1'b0;  bus.pi_num = '0;  bus.pi_cola = 1'b0;
    bus0.pi_buy = 1'b0; bus0.pi_num = '0; bus0.pi_cola = 1'b0;
`ifdef COIN_FEEDER_PAUSE_EN
    bus.pi_pause = 1'b0; bus0.pi_pause = 1'b0;
`endif
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("rst_busy",   bus.po_busy,   1'b0);
    check("rst_money",  bus.po_money,  1'b0);
    check("rst_done",   bus.po_done,   1'b0);
    check("rst_err",    bus.po_err,    1'b0);
    check("rst_bought", bus.po_bought, 8'd0);

    for (int v = 0; v < 9; v++) begin
      for (int j = 0; j < 16; j++) dl[j] = vecs[v].delay;
      exec_buy(vecs[v].num);
      model_total += vecs[v].exp_got;
      mask = '0;
      for (int c = 1; c < 64; c++) if (obs_money[c] === 1'b1) mask[c] = 1'b1;
      check($sformatf("vec%0d_done_cycle", v), obs_done, vecs[v].exp_done);
      check($sformatf("vec%0d_coin_cycles", v), mask, vecs[v].exp_mask);
      check($sformatf("vec%0d_err", v), obs_err, vecs[v].exp_err);
      check($sformatf("vec%0d_bought", v), obs_bought, model_total);
      check($sformatf("vec%0d_busy_gaps", v), busy_gaps, 0);
    end

    // Reset asserted at the edge ending cycle 5 of a two-cola buy.
    bus.pi_buy = 1'b1; bus.pi_num = 4'd2;
    mask = '0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge sys_clk); #1;
      bus.pi_buy = 1'b0;
      if (bus.po_money === 1'b1) mask[c] = 1'b1;
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check("midrst_coins_before", mask, 64'h12);
    check("midrst_busy",   bus.po_busy,   1'b0);
    check("midrst_money",  bus.po_money,  1'b0);
    check("midrst_done",   bus.po_done,   1'b0);
    check("midrst_bought", bus.po_bought, 8'd0);
    @(posedge sys_clk); #1;
    check("midrst_stays_idle", {bus.po_busy, bus.po_money}, 2'b00);
    model_total = 0;

    exec_g0(1, g_done, g_mask, g_bought);
    check("g0_done_cycle", g_done, 4);
    check("g0_coin_cycles", g_mask, 64'hE);
    check("g0_bought", g_bought, 2'd1);
    exec_g0(4, g_done, g_mask, g_bought);
    check("g0_sat_done_cycle", g_done, 13);
    check("g0_sat_coin_cycles", g_mask, 64'h1FFE);
    check("g0_sat_bought", g_bought, 2'd3);

    for (int t = 0; t < 12; t++) begin
      rnum = $urandom_range(0, 4);
      for (int j = 0; j < 16; j++) begin
        rsel  = $urandom_range(0, 9);
        dl[j] = (rsel == 9) ? -1 : rsel;
      end
      model_buy(rnum, m_done, m_err, m_got);
      exec_buy(rnum);
      model_total = (model_total + m_got > 255) ? 255 : model_total + m_got;
      mism = 0;
      for (int c = 1; c <= BUDGET; c++) if (obs_money[c] !== exp_money[c]) mism++;
      check($sformatf("rnd%0d_done_cycle", t), obs_done, m_done);
      check($sformatf("rnd%0d_coin_mismatches", t), mism, 0);
      check($sformatf("rnd%0d_err", t), obs_err, m_err);
      check($sformatf("rnd%0d_bought", t), obs_bought, model_total);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
